// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC generator: default reset PC, 2-bit
// branch-history counter encodings and the saturating counter update.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0001_0000;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating branch-history counters with one combinational
// read port (fetch side) and one write port (resolve side), no bypass.
module bht_2bit
  import fetch_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] wr_ctr_d;

  // Reads see the pre-edge contents, so a same-index write is not forwarded.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    wr_ctr_d = bht_next(ctr_q[wr_idx], wr_taken);
  end

  // NOTE: the whole array is reset so every entry starts weakly-not-taken;
  // this keeps it in flops rather than a RAM macro, which is intended here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= wr_ctr_d;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: BTB + BHT next-PC prediction, mispredict redirect
// and flush, branch statistics. BHT_EN enables the 2-bit BHT (else BTB hit alone).
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BHT_IDX_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] fetch_PC,
  input  logic        BTB_hit,
  input  logic [31:0] BTB_PC,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_PC,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  output logic        flush,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;
  logic [31:0] redirect_pc;
  logic        mispredict;
  logic        bht_taken;

`ifdef BHT_EN
  logic [1:0] bht_ctr;

  bht_2bit #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_q[BHT_IDX_W+1:2]),
    .rd_ctr   (bht_ctr),
    .wr_en    (resolve_valid),
    .wr_idx   (resolve_PC[BHT_IDX_W+1:2]),
    .wr_taken (resolve_taken)
  );

  assign bht_taken = bht_ctr[1];
`else
  assign bht_taken = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pred_taken  = BTB_hit && bht_taken;
    pred_target = pred_taken ? BTB_PC : pc_q + 32'd4;

    mispredict  = resolve_valid &&
                  ((resolve_taken != resolve_pred_taken) ||
                   (resolve_taken && (resolve_target != resolve_pred_target)));
    redirect_pc = resolve_taken ? resolve_target : resolve_PC + 32'd4;

    // A mispredict wins over stall: the stalled instruction is being squashed.
    pc_d = pc_q;
    if (mispredict)  pc_d = redirect_pc;
    else if (!stall) pc_d = pred_target;

    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve_valid && (branch_cnt_q != '1)) branch_cnt_d  = branch_cnt_q + 32'd1;
    if (mispredict && (mispred_cnt_q != '1))   mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign fetch_PC    = pc_q;
  assign flush       = mispredict && !rst;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen; BHT-specific checks are
// compiled in when BHT_EN is defined.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, BTB_hit, pred_taken, flush;
  logic [31:0] fetch_PC, BTB_PC, pred_target, branch_cnt, mispred_cnt;
  logic        resolve_valid, resolve_taken, resolve_pred_taken;
  logic [31:0] resolve_PC, resolve_target, resolve_pred_target;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mp = 0;

  fetch_pc_gen dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .fetch_PC            (fetch_PC),
    .BTB_hit             (BTB_hit),
    .BTB_PC              (BTB_PC),
    .pred_taken          (pred_taken),
    .pred_target         (pred_target),
    .resolve_valid       (resolve_valid),
    .resolve_PC          (resolve_PC),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .flush               (flush),
    .branch_cnt          (branch_cnt),
    .mispred_cnt         (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; BTB_hit = 0; BTB_PC = 0;
    resolve_valid = 0; resolve_PC = 0; resolve_taken = 0; resolve_target = 0;
    resolve_pred_taken = 0; resolve_pred_target = 0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    resolve_valid = 1; resolve_PC = pc; resolve_taken = tk; resolve_target = tgt;
    resolve_pred_taken = ptk; resolve_pred_target = ptgt;
    #1;
  endtask

  task automatic chk_pc(input string name, input logic [31:0] exp);
    checks++;
    if (fetch_PC !== exp) begin
      errors++;
      $display("FAIL %s: fetch_PC got %h expected %h", name, fetch_PC, exp);
    end
  endtask

  task automatic chk_flush(input string name, input logic exp);
    checks++;
    if (flush !== exp) begin
      errors++;
      $display("FAIL %s: flush got %b expected %b", name, flush, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
    checks++;
    if (branch_cnt !== exp_br || mispred_cnt !== exp_mp) begin
      errors++;
      $display("FAIL %s: branch_cnt/mispred_cnt got %h/%h expected %h/%h",
               name, branch_cnt, mispred_cnt, exp_br, exp_mp);
    end
  endtask

  task automatic chk_pred(input string name, input logic exp_t, input logic [31:0] exp_tgt);
    checks++;
    if (pred_taken !== exp_t || pred_target !== exp_tgt) begin
      errors++;
      $display("FAIL %s: pred_taken/pred_target got %b/%h expected %b/%h",
               name, pred_taken, pred_target, exp_t, exp_tgt);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick(); tick();
    chk_pc("reset_pc", 32'h0001_0000);
    chk_flush("reset_flush", 1'b0);
    rst = 0;
    #1;
    chk_cnt("reset_counters");
    tick(); chk_pc("seq_pc1", 32'h0001_0004);
    tick(); chk_pc("seq_pc2", 32'h0001_0008);
  endtask

  task automatic test_predict();
    BTB_hit = 1; BTB_PC = 32'h0001_0100;
    #1;
`ifdef BHT_EN
    chk_pred("untrained_pred", 1'b0, 32'h0001_000C);
`else
    chk_pred("btb_alone_pred", 1'b1, 32'h0001_0100);
`endif
    idle();
    resolve(32'h0001_0040, 1, 32'h0001_0100, 1, 32'h0001_0100);
    chk_flush("correct_pred_flush", 1'b0);
    tick(); exp_br++;
    chk_pc("correct_pred_pc", 32'h0001_000C);
    chk_cnt("correct_pred_cnt");
    resolve(32'h0001_003C, 0, 32'h0, 1, 32'h0001_0100);
    chk_flush("redirect_flush", 1'b1);
    tick(); exp_br++; exp_mp++;
    chk_pc("redirect_pc", 32'h0001_0040);
    idle();
    BTB_hit = 1; BTB_PC = 32'h0001_0100;
    #1;
    chk_pred("trained_pred", 1'b1, 32'h0001_0100);
    tick();
    chk_pc("trained_next_pc", 32'h0001_0100);
    idle();
  endtask

  task automatic test_mispredict_stall();
    stall = 1;
    resolve(32'h0001_0020, 0, 32'h0, 1, 32'h0001_0100);
    chk_flush("stall_mispred_flush", 1'b1);
    tick(); exp_br++; exp_mp++;
    chk_pc("stall_mispred_pc", 32'h0001_0024);
    chk_cnt("stall_mispred_cnt");
    resolve_valid = 0;
    tick();
    chk_pc("stall_hold_pc", 32'h0001_0024);
    stall = 0;
  endtask

  task automatic test_target_mismatch();
    resolve(32'h0001_0020, 1, 32'h0001_0200, 1, 32'h0001_0100);
    chk_flush("tgt_mismatch_flush", 1'b1);
    tick(); exp_br++; exp_mp++;
    chk_pc("tgt_mismatch_pc", 32'h0001_0200);
    resolve(32'h0001_0030, 0, 32'h0001_0300, 0, 32'h0001_0400);
    chk_flush("nt_tgt_ignored_flush", 1'b0);
    tick(); exp_br++;
    chk_pc("nt_tgt_ignored_pc", 32'h0001_0204);
    chk_cnt("tgt_cnt");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      resolve(32'h0001_0040, 1, 32'h0001_0100, 1, 32'h0001_0100);
      tick(); exp_br++;
    end
    resolve(32'h0001_0040, 0, 32'h0, 0, 32'h0);
    tick(); exp_br++;
    chk_pc("sat_seq_pc", 32'h0001_0214);
`ifdef BHT_EN
    resolve(32'h0001_003C, 0, 32'h0, 1, 32'h0001_0100);
    tick(); exp_br++; exp_mp++;
    idle();
    stall = 1; BTB_hit = 1; BTB_PC = 32'h0001_0100;
    resolve(32'h0001_0040, 0, 32'h0, 0, 32'h0);
    chk_pred("sat_no_bypass_pred", 1'b1, 32'h0001_0100);
    tick(); exp_br++;
    resolve_valid = 0;
    #1;
    chk_pred("sat_decayed_pred", 1'b0, 32'h0001_0044);
    idle();
`endif
    chk_cnt("sat_cnt");
    resolve(32'hFFFF_FFF8, 0, 32'h0, 1, 32'h0001_0100);
    tick(); exp_br++; exp_mp++;
    chk_pc("wrap_pre_pc", 32'hFFFF_FFFC);
    idle();
    tick();
    chk_pc("wrap_pc", 32'h0000_0000);
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt_q;
    exp_mp = 32'hFFFF_FFFF;
    resolve(32'h0001_0020, 0, 32'h0, 1, 32'h0001_0100);
    tick(); exp_br++;
    chk_cnt("mispred_cnt_sat");
    chk_pc("mispred_sat_pc", 32'h0001_0024);
    idle();
  endtask

  task automatic test_reset_mid_redirect();
`ifdef BHT_EN
    for (int i = 0; i < 2; i++) begin
      resolve(32'h0001_0000, 1, 32'h0001_0100, 1, 32'h0001_0100);
      tick();
    end
`endif
    rst = 1; stall = 1;
    resolve(32'h0001_0020, 0, 32'h0, 1, 32'h0001_0100);
    chk_flush("rst_mispred_flush", 1'b0);
    tick();
    exp_br = 0; exp_mp = 0;
    chk_pc("rst_mispred_pc", 32'h0001_0000);
    chk_cnt("rst_mispred_cnt");
    rst = 0;
    idle();
`ifdef BHT_EN
    BTB_hit = 1; BTB_PC = 32'h0001_0100;
    #1;
    chk_pred("rst_bht_wnt", 1'b0, 32'h0001_0004);
    idle();
`endif
    tick();
    chk_pc("post_rst_pc", 32'h0001_0004);
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_predict();
    test_mispredict_stall();
    test_target_mismatch();
    test_saturation();
    test_reset_mid_redirect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
